// File: rtl/alu_result_sink_if.sv
// Handshake bundle between the command controller, the ALU result port and the
// downstream consumer of alu_result_sink. out_csum exists only with ALU_SINK_CHECKSUM_EN.
interface alu_result_sink_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_count;
  logic        cmd_ready;
  logic        cmd_done;
  logic        res_valid;
  logic [10:0] res_data;
  logic        res_ready;
  logic [2:0]  res_op;
  logic        out_valid;
  logic [10:0] out_data;
  logic [2:0]  out_op;
  logic        out_last;
  logic        out_ready;
`ifdef ALU_SINK_CHECKSUM_EN
  logic [15:0] out_csum;

  modport master (
    output cmd_valid, cmd_op, cmd_count, res_valid, res_data, out_ready,
    input  cmd_ready, cmd_done, res_ready, res_op,
    input  out_valid, out_data, out_op, out_last, out_csum
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, res_valid, res_data, out_ready,
    output cmd_ready, cmd_done, res_ready, res_op,
    output out_valid, out_data, out_op, out_last, out_csum
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_count, res_valid, res_data, out_ready,
    input  cmd_ready, cmd_done, res_ready, res_op,
    input  out_valid, out_data, out_op, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, res_valid, res_data, out_ready,
    output cmd_ready, cmd_done, res_ready, res_op,
    output out_valid, out_data, out_op, out_last
  );
`endif
endinterface

// File: rtl/alu_result_sink.sv
// Consumes ALU results per command into a 2-entry skid buffer and streams them out tagged.
// Optional per-command checksum on out_csum when ALU_SINK_CHECKSUM_EN is defined.
module alu_result_sink (
  input logic             clk,
  input logic             rstn,
  alu_result_sink_if.slave bus
);

  localparam int unsigned DATA_W = 11;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned REM_W  = 5;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   op;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic              cmd_ready_c, res_ready_c;
  logic              accept_c, push_c, pop_c, last_push_c;
  logic [REM_W-1:0]  remaining_q, remaining_d;
  logic [OP_W-1:0]   op_q, op_d;
  entry_t            mem_q [2];
  entry_t            mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  entry_t            head_q, head_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = RUN;
      RUN:     if (push_c && last_push_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes; res_ready depends on registers only so out_ready never reaches the ALU.
  always_comb begin
    cmd_ready_c = (state_q == IDLE);
    res_ready_c = (state_q == RUN) && (occ_q != OCC_W'(2));
    accept_c    = cmd_ready_c && bus.cmd_valid;
    push_c      = res_ready_c && bus.res_valid;
    last_push_c = (remaining_q == REM_W'(1));
    pop_c       = (occ_q != OCC_W'(0)) && bus.out_ready;
  end

  always_comb begin
    remaining_d = remaining_q;
    op_d        = op_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    head_d      = head_q;

    if (accept_c) begin
      op_d        = bus.cmd_op;
      remaining_d = (bus.cmd_count == 4'd0) ? REM_W'(16) : {1'b0, bus.cmd_count};
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = '{data: bus.res_data, op: op_q, last: last_push_c};
      wr_ptr_d        = ~wr_ptr_q;
      remaining_d     = remaining_q - REM_W'(1);
    end

    if (pop_c) rd_ptr_d = ~rd_ptr_q;

    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // Output fields follow the head entry and keep their last value once the buffer empties.
    if (occ_d != OCC_W'(0)) head_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining_q <= '0;
      op_q        <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      head_q      <= '0;
    end else begin
      remaining_q <= remaining_d;
      op_q        <= op_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.cmd_done  = push_c && last_push_c;
  assign bus.res_ready = res_ready_c;
  assign bus.res_op    = op_q;
  assign bus.out_valid = (occ_q != OCC_W'(0));
  assign bus.out_data  = head_q.data;
  assign bus.out_op    = head_q.op;
  assign bus.out_last  = head_q.last;

`ifdef ALU_SINK_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  // Running sum of every result captured for the current command.
  always_comb begin
    csum_d = csum_q;
    if (accept_c)    csum_d = '0;
    else if (push_c) csum_d = csum_q + CSUM_W'(bus.res_data);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign bus.out_csum = csum_q;
`endif

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed self-checking bench for alu_result_sink: reset, streaming, 16-count,
// back-pressure, back-to-back commands, idle result strobes and mid-command reset.
module tb_alu_result_sink;

  typedef struct packed {
    logic [10:0] d;
    logic [2:0]  op;
    logic        last;
  } rec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_result_sink_if bus();

  alu_result_sink dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          total = 0;
  int          bad = 0;
  rec_t        q[$];
  int          done_cnt = 0;
  int          hs_cnt = 0;
  int          op_glitch = 0;
  int          early_rdy = 0;
  int          out_mode = 0;
  logic [10:0] dat [16];

  // out_ready pattern: 0 = low, 1 = high, 2 = toggle each cycle
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ~bus.out_ready;
      endcase
    end
  end

  // Passive monitor: collects output beats and counts handshakes and res_op changes.
  initial begin
    logic [2:0] prev_op;
    logic       prev_acc;
    prev_op  = 3'd0;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.out_valid && bus.out_ready) q.push_back('{d: bus.out_data, op: bus.out_op, last: bus.out_last});
        if (bus.cmd_done) done_cnt++;
        if (bus.res_valid && bus.res_ready) hs_cnt++;
        if (bus.res_op !== prev_op && !prev_acc) op_glitch++;
        prev_acc = bus.cmd_valid && bus.cmd_ready;
        prev_op  = bus.res_op;
      end else begin
        prev_acc = 1'b0;
        prev_op  = bus.res_op;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a command, then feeds dat[0..n-1] with res_valid held high.
  task automatic drive_cmd(input logic [2:0] op, input logic [3:0] cnt, input int n);
    bit acc;
    bit hs;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      step();
    end
    bus.cmd_valid = 1'b0;
    total++;
    if (!acc) begin bad++; $display("FAIL cmd_accept timeout op=%0d", op); end
    bus.res_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.res_data = dat[i];
      hs = 1'b0;
      for (int j = 0; j < 60 && !hs; j++) begin
        @(negedge clk);
        hs = bus.res_ready;
        if (bus.cmd_ready) early_rdy++;
        step();
      end
      total++;
      if (!hs) begin bad++; $display("FAIL res_handshake timeout idx=%0d", i); end
    end
    bus.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_count = 4'd0;
    bus.res_valid = 1'b0; bus.res_data = 11'd0;
    rstn = 1'b0;
    step(); step();
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.cmd_done !== 1'b0) begin bad++; $display("FAIL rst_cmd_done got=%b exp=0", bus.cmd_done); end
    total++; if (bus.res_ready !== 1'b0) begin bad++; $display("FAIL rst_res_ready got=%b exp=0", bus.res_ready); end
    total++; if (bus.res_op !== 3'd0) begin bad++; $display("FAIL rst_res_op got=%0d exp=0", bus.res_op); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 11'd0) begin bad++; $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); end
    total++; if (bus.out_op !== 3'd0) begin bad++; $display("FAIL rst_out_op got=%0d exp=0", bus.out_op); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
`ifdef ALU_SINK_CHECKSUM_EN
    total++; if (bus.out_csum !== 16'd0) begin bad++; $display("FAIL rst_out_csum got=%0d exp=0", bus.out_csum); end
`endif
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0;
    out_mode = 1;
    step();
    q.delete();
    d0 = done_cnt;
    early_rdy = 0;
    dat[0] = 11'd5; dat[1] = 11'd9; dat[2] = 11'd300;
    drive_cmd(3'd6, 4'd3, 3);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_cmd_ready_after got=%b exp=1", bus.cmd_ready); end
    total++; if (early_rdy !== 0) begin bad++; $display("FAIL basic_cmd_ready_in_run got=%0d exp=0", early_rdy); end
`ifdef ALU_SINK_CHECKSUM_EN
    total++; if (bus.out_csum !== 16'd314) begin bad++; $display("FAIL basic_csum got=%0d exp=314", bus.out_csum); end
`endif
    repeat (4) step();
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    total++;
    if (q.size() !== 3) begin
      bad++; $display("FAIL basic_count got=%0d exp=3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q[i].d !== dat[i] || q[i].op !== 3'd6 || q[i].last !== (i == 2)) begin
          bad++;
          $display("FAIL basic_beat%0d got=%0d/%0d/%b exp=%0d/6/%b", i, q[i].d, q[i].op, q[i].last, dat[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_count16();
    int h0;
    int nlast;
    out_mode = 1;
    q.delete();
    h0 = hs_cnt;
    early_rdy = 0;
    for (int i = 0; i < 16; i++) dat[i] = 11'(i * 3 + 1);
    drive_cmd(3'd2, 4'd0, 16);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL c16_cmd_ready_after got=%b exp=1", bus.cmd_ready); end
    total++; if (early_rdy !== 0) begin bad++; $display("FAIL c16_cmd_ready_early got=%0d exp=0", early_rdy); end
`ifdef ALU_SINK_CHECKSUM_EN
    total++; if (bus.out_csum !== 16'd376) begin bad++; $display("FAIL c16_csum got=%0d exp=376", bus.out_csum); end
`endif
    repeat (4) step();
    total++; if (hs_cnt - h0 !== 16) begin bad++; $display("FAIL c16_handshakes got=%0d exp=16", hs_cnt - h0); end
    total++;
    if (q.size() !== 16) begin
      bad++; $display("FAIL c16_count got=%0d exp=16", q.size());
    end else begin
      nlast = 0;
      for (int i = 0; i < 15; i++) if (q[i].last) nlast++;
      total++; if (nlast !== 0) begin bad++; $display("FAIL c16_early_last got=%0d exp=0", nlast); end
      total++;
      if (q[15].last !== 1'b1 || q[15].d !== 11'd46 || q[15].op !== 3'd2) begin
        bad++; $display("FAIL c16_final got=%0d/%0d/%b exp=46/2/1", q[15].d, q[15].op, q[15].last);
      end
    end
  endtask

  task automatic test_backpressure();
    int h0;
    out_mode = 0;
    step();
    q.delete();
    h0 = hs_cnt;
    dat[0] = 11'd10; dat[1] = 11'd20; dat[2] = 11'd30; dat[3] = 11'd40;
    fork
      drive_cmd(3'd5, 4'd4, 4);
      begin
        repeat (8) step();
        total++; if (hs_cnt - h0 !== 2) begin bad++; $display("FAIL bp_captured got=%0d exp=2", hs_cnt - h0); end
        total++; if (bus.res_ready !== 1'b0) begin bad++; $display("FAIL bp_res_ready_full got=%b exp=0", bus.res_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 11'd10) begin
          bad++; $display("FAIL bp_head got=%b/%0d exp=1/10", bus.out_valid, bus.out_data);
        end
        out_mode = 1;
        step();
        #1;
        total++; if (bus.out_ready !== 1'b1 || bus.res_ready !== 1'b0) begin
          bad++; $display("FAIL bp_full_with_out_ready got=%b/%b exp=1/0", bus.out_ready, bus.res_ready);
        end
      end
    join
    repeat (6) step();
    total++;
    if (q.size() !== 4) begin
      bad++; $display("FAIL bp_count got=%0d exp=4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q[i].d !== dat[i] || q[i].op !== 3'd5 || q[i].last !== (i == 3)) begin
          bad++;
          $display("FAIL bp_beat%0d got=%0d/%0d/%b exp=%0d/5/%b", i, q[i].d, q[i].op, q[i].last, dat[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ed [3];
    logic [2:0]  eo [3];
    logic        el [3];
    ed[0] = 11'd7;   eo[0] = 3'd0; el[0] = 1'b1;
    ed[1] = 11'd100; eo[1] = 3'd7; el[1] = 1'b0;
    ed[2] = 11'd200; eo[2] = 3'd7; el[2] = 1'b1;
    out_mode = 2;
    q.delete();
    op_glitch = 0;
    dat[0] = 11'd7;
    drive_cmd(3'd0, 4'd1, 1);
    dat[0] = 11'd100; dat[1] = 11'd200;
    drive_cmd(3'd7, 4'd2, 2);
    repeat (8) step();
    total++; if (op_glitch !== 0) begin bad++; $display("FAIL b2b_res_op_glitch got=%0d exp=0", op_glitch); end
    total++; if (bus.res_op !== 3'd7) begin bad++; $display("FAIL b2b_res_op_hold got=%0d exp=7", bus.res_op); end
    total++;
    if (q.size() !== 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp=3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q[i].d !== ed[i] || q[i].op !== eo[i] || q[i].last !== el[i]) begin
          bad++;
          $display("FAIL b2b_beat%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, q[i].d, q[i].op, q[i].last, ed[i], eo[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_idle_res();
    int h0;
    out_mode = 1;
    step();
    h0 = hs_cnt;
    bus.res_valid = 1'b1;
    bus.res_data  = 11'd55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.res_ready !== 1'b0) begin bad++; $display("FAIL idle_res_ready cyc%0d got=%b exp=0", i, bus.res_ready); end
      step();
    end
    bus.res_valid = 1'b0;
    total++; if (hs_cnt - h0 !== 0) begin bad++; $display("FAIL idle_handshakes got=%0d exp=0", hs_cnt - h0); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    out_mode = 0;
    step();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_count = 4'd4;
    step();
    bus.cmd_valid = 1'b0;
    bus.res_valid = 1'b1;
    bus.res_data  = 11'd1;
    repeat (4) step();
    total++; if (bus.out_valid !== 1'b1 || bus.res_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_full got=%b/%b exp=1/0", bus.out_valid, bus.res_ready);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.cmd_done !== 1'b0) begin bad++; $display("FAIL rmid_cmd_done got=%b exp=0", bus.cmd_done); end
    total++; if (bus.res_ready !== 1'b0) begin bad++; $display("FAIL rmid_res_ready got=%b exp=0", bus.res_ready); end
    total++; if (bus.res_op !== 3'd0) begin bad++; $display("FAIL rmid_res_op got=%0d exp=0", bus.res_op); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 11'd0 || bus.out_op !== 3'd0 || bus.out_last !== 1'b0) begin
      bad++; $display("FAIL rmid_out_fields got=%0d/%0d/%b exp=0/0/0", bus.out_data, bus.out_op, bus.out_last);
    end
`ifdef ALU_SINK_CHECKSUM_EN
    total++; if (bus.out_csum !== 16'd0) begin bad++; $display("FAIL rmid_csum got=%0d exp=0", bus.out_csum); end
`endif
    bus.res_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    total++; if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_after got=%b/%b exp=1/0", bus.cmd_ready, bus.out_valid);
    end
    out_mode = 1;
    q.delete();
    dat[0] = 11'd77;
    drive_cmd(3'd1, 4'd1, 1);
    repeat (4) step();
    total++;
    if (q.size() !== 1) begin
      bad++; $display("FAIL rmid_next_count got=%0d exp=1", q.size());
    end else if (q[0].d !== 11'd77 || q[0].op !== 3'd1 || q[0].last !== 1'b1) begin
      bad++; $display("FAIL rmid_next_beat got=%0d/%0d/%b exp=77/1/1", q[0].d, q[0].op, q[0].last);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count16();
    test_backpressure();
    test_back_to_back();
    test_idle_res();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
